// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared arbiter state encoding and I2C byte constants
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam int I2C_RW_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_BUSY    = 3'd2,
    ST_DONE    = 3'd3,
    ST_RECOVER = 3'd4
  } arb_state_t;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// rtl/i2c_bus_arbiter_if.sv - pins between the arbiter and the shared i2c_controller master
interface i2c_bus_arbiter_if;
  import i2c_pkg::*;

  logic [I2C_BYTE_W-1:0] m_addr;
  logic [I2C_BYTE_W-1:0] m_data_in;
  logic                  m_enable;
  logic                  m_restart;
  logic                  m_ready;
  logic [I2C_BYTE_W-1:0] m_data_out;

  modport master (
    output m_addr, m_data_in, m_enable, m_restart,
    input  m_ready, m_data_out
  );

  modport slave (
    input  m_addr, m_data_in, m_enable, m_restart,
    output m_ready, m_data_out
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin picker, scans from ptr+1 with wrap
module i2c_rr_pick #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin share of one i2c_controller master with lock and watchdog
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              lock,
  input  logic [NUM_REQ*I2C_BYTE_W-1:0]   req_addr,
  input  logic [NUM_REQ*I2C_BYTE_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              done,
  output logic [I2C_BYTE_W-1:0]           rsp_rdata,
  output logic                            rsp_timeout,
  i2c_bus_arbiter_if.master               bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t             state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [I2C_BYTE_W-1:0]  rdata_q, rdata_d;
  logic                   tout_q, tout_d;
  logic [I2C_BYTE_W-1:0]  addr_q, addr_d;
  logic [I2C_BYTE_W-1:0]  wdata_q, wdata_d;
  logic                   en_q, en_d;
  logic                   rs_q, rs_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   lock_vld_q, lock_vld_d;
  logic [PTR_W-1:0]       lock_own_q, lock_own_d;
  logic [PTR_W-1:0]       own_q, own_d;
  logic [CNT_W-1:0]       wdog_q, wdog_d;

  logic [NUM_REQ-1:0]     pick_onehot;
  logic                   pick_valid;
  logic [PTR_W-1:0]       pick_idx;
  logic [PTR_W-1:0]       win_idx;
  logic                   lock_hit;
  logic                   wdog_expired;

  i2c_rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_onehot),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_idx = PTR_W'(i);
    end
  end

  assign lock_hit     = lock_vld_q && req[lock_own_q];
  assign win_idx      = lock_hit ? lock_own_q : pick_idx;
  assign wdog_expired = (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      tout_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      en_q       <= 1'b0;
      rs_q       <= 1'b0;
      ptr_q      <= PTR_W'(NUM_REQ - 1);
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
      own_q      <= '0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      tout_q     <= tout_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      en_q       <= en_d;
      rs_q       <= rs_d;
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      own_q      <= own_d;
      wdog_q     <= wdog_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    tout_d     = tout_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    en_d       = en_q;
    rs_d       = rs_q;
    ptr_d      = ptr_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    own_d      = own_q;
    wdog_d     = wdog_q;

    unique case (state_q)
      ST_IDLE: begin
        // A lock whose owner has gone quiet is abandoned rather than stalling others.
        if (lock_vld_q && !req[lock_own_q]) lock_vld_d = 1'b0;
        if (bus.m_ready && pick_valid) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          own_d          = win_idx;
          addr_d         = req_addr[int'(win_idx)*I2C_BYTE_W +: I2C_BYTE_W];
          wdata_d        = req_wdata[int'(win_idx)*I2C_BYTE_W +: I2C_BYTE_W];
          en_d           = 1'b1;
          rs_d           = lock_hit;
          wdog_d         = '0;
          state_d        = ST_LAUNCH;
        end
      end
      ST_LAUNCH, ST_BUSY: begin
        wdog_d = wdog_q + CNT_W'(1);
        if (wdog_expired) begin
          en_d          = 1'b0;
          tout_d        = 1'b1;
          done_d[own_q] = 1'b1;
          state_d       = ST_DONE;
        end else if (state_q == ST_LAUNCH) begin
          if (!bus.m_ready) begin
            en_d    = 1'b0;
            state_d = ST_BUSY;
          end
        end else if (bus.m_ready) begin
          rdata_d       = bus.m_data_out;
          done_d[own_q] = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        gnt_d  = '0;
        rs_d   = 1'b0;
        tout_d = 1'b0;
        ptr_d  = own_q;
        if (tout_q) begin
          lock_vld_d = 1'b0;
          state_d    = ST_RECOVER;
        end else begin
          lock_vld_d = lock[own_q];
          lock_own_d = own_q;
          state_d    = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        if (bus.m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_timeout   = tout_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_data_in = wdata_q;
  assign bus.m_enable  = en_q;
  assign bus.m_restart = rs_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - self-checking bench for i2c_bus_arbiter with a stretching master model
module tb_i2c_bus_arbiter;
  import i2c_pkg::*;

  localparam int NR  = 4;
  localparam int TMO = 200;
  localparam logic [7:0] RD_ADDR = 8'h98 | (8'h01 << I2C_RW_BIT);

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, lock;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  gnt, done;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;

  i2c_bus_arbiter_if bus();

  i2c_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .done        (done),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Master model: drops ready when it sees enable, holds it low for hold_cycles
  // (forever while stretch is set), then raises it presenting rd_data.
  logic       m_rdy  = 1'b1;
  logic [7:0] m_dout = 8'h00;
  int         m_cnt  = 0;
  bit         stretch = 1'b0;
  int         hold_cycles = 4;
  logic [7:0] rd_data = 8'h00;

  assign bus.m_ready    = m_rdy;
  assign bus.m_data_out = m_dout;

  always @(posedge clk) begin
    if (m_rdy) begin
      if (bus.m_enable) begin
        m_rdy <= 1'b0;
        m_cnt <= hold_cycles;
      end
    end else if (!stretch) begin
      if (m_cnt <= 1) begin
        m_rdy  <= 1'b1;
        m_dout <= rd_data;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int         n_cmp = 0;
  int         n_err = 0;
  int         ptr_m;
  int         lock_m;
  logic [7:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input logic [3:0] r, input int p);
    for (int k = 1; k <= NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_timeout"}, rsp_timeout, 0);
    chk({tag, "_m_addr"}, bus.m_addr, 0);
    chk({tag, "_m_data_in"}, bus.m_data_in, 0);
    chk({tag, "_m_enable"}, bus.m_enable, 0);
    chk({tag, "_m_restart"}, bus.m_restart, 0);
  endtask

  task automatic model_reset();
    ptr_m   = NR - 1;
    lock_m  = -1;
    last_rd = 8'h00;
  endtask

  // One full transaction: predict owner, check launch, completion and release.
  task automatic serve(input bit exp_to, input bit chk_lat);
    int c;
    int w;
    bit rs;
    bit stable;
    logic [3:0] g0;
    logic [7:0] a0, d0;
    c = 0;
    while (gnt === 4'b0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("gnt_seen", (gnt !== 4'b0), 1);
    if (chk_lat) chk("gnt_latency", c, 1);
    if (lock_m >= 0 && req[lock_m]) begin
      w  = lock_m;
      rs = 1'b1;
    end else begin
      w      = rr_next(req, ptr_m);
      rs     = 1'b0;
      lock_m = -1;
    end
    chk("gnt_owner", gnt, 32'd1 << w);
    chk("m_restart", bus.m_restart, rs);
    chk("m_enable", bus.m_enable, 1);
    chk("m_addr", bus.m_addr, req_addr[w*8 +: 8]);
    chk("m_data_in", bus.m_data_in, req_wdata[w*8 +: 8]);
    g0 = gnt;
    a0 = bus.m_addr;
    d0 = bus.m_data_in;
    stable = 1'b1;
    c = 0;
    while (done === 4'b0 && c < 1000) begin
      @(negedge clk);
      c++;
      if (done === 4'b0 && (gnt !== g0 || bus.m_addr !== a0 || bus.m_data_in !== d0)) stable = 1'b0;
    end
    chk("done_owner", done, 32'd1 << w);
    chk("gnt_at_done", gnt, 32'd1 << w);
    chk("held_stable", stable, 1);
    chk("rsp_timeout", rsp_timeout, exp_to);
    if (exp_to) begin
      chk("timeout_cycle", c, TMO);
      chk("rdata_kept", rsp_rdata, last_rd);
    end else begin
      chk("rsp_rdata", rsp_rdata, rd_data);
      last_rd = rd_data;
    end
    ptr_m  = w;
    lock_m = (!exp_to && lock[w]) ? w : -1;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("gnt_release", gnt, 0);
  endtask

  initial begin
    int c;
    int bad;
    rst = 1'b1;
    req = '0;
    lock = '0;
    req_addr = '0;
    req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_zero("reset");

    // Single write to requester 0
    req_addr[7:0]  = 8'h98;
    req_wdata[7:0] = 8'h43;
    hold_cycles = 40;
    rd_data = 8'h5a;
    req = 4'b0001;
    serve(1'b0, 1'b1);
    req = '0;

    // Read on requester 2
    req_addr[23:16] = RD_ADDR;
    hold_cycles = 10;
    rd_data = 8'h81;
    req = 4'b0100;
    serve(1'b0, 1'b1);
    req = '0;

    // Round-robin from reset with everyone requesting
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req_addr  = $urandom;
    req_wdata = $urandom;
    hold_cycles = 3;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rd_data = 8'($urandom);
      serve(1'b0, 1'b1);
    end
    req = '0;

    // Lock on requester 1 while 3 waits, then release
    req = 4'b1010;
    lock = 4'b0010;
    serve(1'b0, 1'b1);
    lock = 4'b0000;
    serve(1'b0, 1'b1);
    serve(1'b0, 1'b1);
    req = '0;

    // Watchdog: master stretches forever
    req = 4'b0001;
    hold_cycles = 5;
    stretch = 1'b1;
    serve(1'b1, 1'b1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt !== 4'b0) bad++;
    end
    chk("recover_no_grant", bad, 0);
    stretch = 1'b0;
    rd_data = 8'h3c;
    serve(1'b0, 1'b0);
    req = '0;

    // Reset while BUSY
    hold_cycles = 40;
    req = 4'b0001;
    c = 0;
    while (gnt === 4'b0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("pre_reset_gnt", gnt, 4'b0001);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_zero("mid_reset");
    req = 4'b1111;
    rd_data = 8'he7;
    hold_cycles = 6;
    serve(1'b0, 1'b0);
    req = '0;

    // Randomized requests, locks and master timing
    for (int i = 0; i < 40; i++) begin
      req_addr    = $urandom;
      req_wdata   = $urandom;
      lock        = 4'($urandom);
      hold_cycles = $urandom_range(1, 12);
      rd_data     = 8'($urandom);
      req         = 4'($urandom_range(1, 15));
      serve(1'b0, 1'b1);
    end
    req = '0;
    lock = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
